// File: rtl/cla_sub64_seq_pkg.sv
// Shared constants and state encoding for the sequential CLA subtractor.
package cla_sub64_seq_pkg;

  localparam int DATA_W  = 64;
  localparam int SLICE_W = 16;
  localparam int GRP_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/cla_sub64_seq_cla16.sv
// 16-bit two-level carry-lookahead adder slice (4-bit groups).
module cla_sub64_seq_cla16
  import cla_sub64_seq_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  localparam int NGRP = SLICE_W / GRP_W;

  logic [SLICE_W-1:0] g, p, c;
  logic [NGRP-1:0]    gg, gp;
  logic [NGRP:0]      gc;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    gg = '0;
    gp = '0;
    gc = '0;
    c  = '0;
    for (int j = 0; j < NGRP; j++) begin
      gg[j] = g[4*j+3]
            | (p[4*j+3] & g[4*j+2])
            | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      gp[j] = &p[4*j +: 4];
    end
    gc[0] = cin;
    for (int j = 0; j < NGRP; j++)
      gc[j+1] = gg[j] | (gp[j] & gc[j]);
    for (int i = 0; i < SLICE_W; i++) begin
      if (i % GRP_W == 0)
        c[i] = gc[i/GRP_W];
      else
        c[i] = g[i-1] | (p[i-1] & c[i-1]);
    end
  end

  assign sum  = p ^ c;
  assign cout = gc[NGRP];

endmodule

// File: rtl/cla_sub64_seq.sv
// Multi-cycle subtractor d = x - y - bIn using one CLA slice per cycle.
module cla_sub64_seq
  import cla_sub64_seq_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int SLICE = SLICE_W
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             bIn,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] d,
  output logic             bOut,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int KW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

  state_e state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] xr_q, xr_d;
  logic [WIDTH-1:0] yn_q, yn_d;
  logic [WIDTH-1:0] d_q, d_d, d_full;
  logic c_q, c_d;
  logic bout_q, bout_d;
  logic zero_q, zero_d;
  logic neg_q, neg_d;
  logic ovf_q, ovf_d;

  logic [SLICE-1:0] sa, sb, ssum;
  logic             scout;
  logic             accept;
  logic             last;

  assign sa   = xr_q[k_q*SLICE +: SLICE];
  assign sb   = yn_q[k_q*SLICE +: SLICE];
  assign last = (k_q == K_LAST);

  cla_sub64_seq_cla16 u_slice (
    .a    (sa),
    .b    (sb),
    .cin  (c_q),
    .sum  (ssum),
    .cout (scout)
  );

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q <= IDLE;
      k_q     <= '0;
      xr_q    <= '0;
      yn_q    <= '0;
      d_q     <= '0;
      c_q     <= 1'b0;
      bout_q  <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      xr_q    <= xr_d;
      yn_q    <= yn_d;
      d_q     <= d_d;
      c_q     <= c_d;
      bout_q  <= bout_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = RUN;
      RUN:  if (last) state_d = DONE;
      DONE: if (outReady)
              state_d = inValid ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    inReady  = (state_q == IDLE)
             | ((state_q == DONE) & outReady);
    outValid = (state_q == DONE);
  end

  assign accept = inValid & inReady;

  // x - y - b is formed as x + ~y + ~b; bIn enters as the first carry
  always_comb begin
    k_d    = k_q;
    xr_d   = xr_q;
    yn_d   = yn_q;
    d_d    = d_q;
    c_d    = c_q;
    bout_d = bout_q;
    zero_d = zero_q;
    neg_d  = neg_q;
    ovf_d  = ovf_q;
    d_full = d_q;
    d_full[k_q*SLICE +: SLICE] = ssum;
    if (accept) begin
      xr_d = x;
      yn_d = ~y;
      c_d  = ~bIn;
      k_d  = '0;
    end else if (state_q == RUN) begin
      d_d = d_full;
      c_d = scout;
      k_d = last ? '0 : k_q + 1'b1;
      if (last) begin
        bout_d = ~scout;
        zero_d = (d_full == '0);
        neg_d  = d_full[WIDTH-1];
        ovf_d  = (xr_q[WIDTH-1] == yn_q[WIDTH-1])
               & (d_full[WIDTH-1] != xr_q[WIDTH-1]);
      end
    end
  end

  assign d    = d_q;
  assign bOut = bout_q;
  assign zero = zero_q;
  assign neg  = neg_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_cla_sub64_seq.sv
// Directed-vector bench for the sequential 64-bit subtractor.
module tb_cla_sub64_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] x;
  logic [63:0] y;
  logic        b_in;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] d;
  logic        b_out;
  logic        zero;
  logic        neg;
  logic        ovf;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cla_sub64_seq dut (
    .clk      (clk),
    .rstN     (rst_n),
    .inValid  (in_valid),
    .inReady  (in_ready),
    .x        (x),
    .y        (y),
    .bIn      (b_in),
    .outValid (out_valid),
    .outReady (out_ready),
    .d        (d),
    .bOut     (b_out),
    .zero     (zero),
    .neg      (neg),
    .ovf      (ovf)
  );

  task automatic apply(input logic [63:0] xv, input logic [63:0] yv,
                       input logic bv, output int lat);
    int w;
    x = xv;
    y = yv;
    b_in = bv;
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    x = ~xv;
    y = xv;
    b_in = ~bv;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic retire();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    x = 64'hDEAD_BEEF_0000_1111;
    y = 64'h1234;
    b_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({out_valid, b_out, zero, neg, ovf} !== 5'b0) begin
      n_err++;
      $display("FAIL rst_flags got %b want 00000",
               {out_valid, b_out, zero, neg, ovf});
    end
    n_vec++;
    if (d !== 64'h0) begin
      n_err++;
      $display("FAIL rst_d got %h want 0", d);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rst_inready got %b want 1", in_ready);
    end
  endtask

  task automatic test_basic();
    int lat;
    apply(64'h10, 64'h3, 1'b0, lat);
    n_vec++;
    if (lat !== 4) begin
      n_err++;
      $display("FAIL basic_latency got %0d want 4", lat);
    end
    n_vec++;
    if (d !== 64'hD) begin
      n_err++;
      $display("FAIL basic_d got %h want d", d);
    end
    n_vec++;
    if ({b_out, zero, neg, ovf} !== 4'b0000) begin
      n_err++;
      $display("FAIL basic_flags got %b want 0000",
               {b_out, zero, neg, ovf});
    end
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL basic_inready_stall got %b want 0", in_ready);
    end
    retire();
  endtask

  task automatic test_borrow();
    int lat;
    apply(64'h0, 64'h1, 1'b0, lat);
    n_vec++;
    if (d !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      n_err++;
      $display("FAIL under_d got %h want ffffffffffffffff", d);
    end
    n_vec++;
    if ({b_out, zero, neg, ovf} !== 4'b1010) begin
      n_err++;
      $display("FAIL under_flags got %b want 1010",
               {b_out, zero, neg, ovf});
    end
    retire();
  endtask

  task automatic test_overflow();
    int lat;
    apply(64'h8000_0000_0000_0000, 64'h1, 1'b0, lat);
    n_vec++;
    if (d !== 64'h7FFF_FFFF_FFFF_FFFF) begin
      n_err++;
      $display("FAIL ovf_neg_d got %h want 7fffffffffffffff", d);
    end
    n_vec++;
    if ({b_out, zero, neg, ovf} !== 4'b0001) begin
      n_err++;
      $display("FAIL ovf_neg_flags got %b want 0001",
               {b_out, zero, neg, ovf});
    end
    retire();
    apply(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, lat);
    n_vec++;
    if (d !== 64'h8000_0000_0000_0000) begin
      n_err++;
      $display("FAIL ovf_pos_d got %h want 8000000000000000", d);
    end
    n_vec++;
    if ({b_out, zero, neg, ovf} !== 4'b1011) begin
      n_err++;
      $display("FAIL ovf_pos_flags got %b want 1011",
               {b_out, zero, neg, ovf});
    end
    retire();
    apply(64'h0000_0001_0000_0000, 64'h1, 1'b0, lat);
    n_vec++;
    if (d !== 64'h0000_0000_FFFF_FFFF) begin
      n_err++;
      $display("FAIL xslice_d got %h want 00000000ffffffff", d);
    end
    n_vec++;
    if ({b_out, zero, neg, ovf} !== 4'b0000) begin
      n_err++;
      $display("FAIL xslice_flags got %b want 0000",
               {b_out, zero, neg, ovf});
    end
    retire();
  endtask

  task automatic test_equal();
    int lat;
    apply(64'hA5A5_A5A5_A5A5_A5A5, 64'hA5A5_A5A5_A5A5_A5A5, 1'b0, lat);
    n_vec++;
    if (d !== 64'h0) begin
      n_err++;
      $display("FAIL eq_d got %h want 0", d);
    end
    n_vec++;
    if ({b_out, zero, neg, ovf} !== 4'b0100) begin
      n_err++;
      $display("FAIL eq_flags got %b want 0100",
               {b_out, zero, neg, ovf});
    end
    retire();
    apply(64'hA5A5_A5A5_A5A5_A5A5, 64'hA5A5_A5A5_A5A5_A5A5, 1'b1, lat);
    n_vec++;
    if (d !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      n_err++;
      $display("FAIL eqb_d got %h want ffffffffffffffff", d);
    end
    n_vec++;
    if ({b_out, zero, neg, ovf} !== 4'b1010) begin
      n_err++;
      $display("FAIL eqb_flags got %b want 1010",
               {b_out, zero, neg, ovf});
    end
    retire();
  endtask

  task automatic test_back_to_back();
    int lat;
    apply(64'd100, 64'd1, 1'b0, lat);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if (out_valid !== 1'b1 || d !== 64'd99) begin
        n_err++;
        $display("FAIL stall_hold%0d got v=%b d=%0d want v=1 d=99",
                 i, out_valid, d);
      end
    end
    out_ready = 1'b1;
    in_valid = 1'b1;
    x = 64'd50;
    y = 64'd8;
    b_in = 1'b0;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_inready got %b want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    x = 64'h0;
    y = 64'hFFFF;
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_retired got %b want 0", out_valid);
    end
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    n_vec++;
    if (lat !== 4) begin
      n_err++;
      $display("FAIL b2b_latency got %0d want 4", lat);
    end
    n_vec++;
    if (d !== 64'd42) begin
      n_err++;
      $display("FAIL b2b_d got %0d want 42", d);
    end
    retire();
  endtask

  task automatic test_reset_mid_run();
    logic seen;
    x = 64'h1234_5678_9ABC_DEF0;
    y = 64'h1;
    b_in = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    n_vec++;
    if (seen !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_outvalid got %b want 0", seen);
    end
    n_vec++;
    if (in_ready !== 1'b1 || d !== 64'h0) begin
      n_err++;
      $display("FAIL midrst_idle got r=%b d=%h want r=1 d=0",
               in_ready, d);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_overflow();
    test_equal();
    test_back_to_back();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
